// File: rtl/ccd_frame_capture_ctrl.sv
// ccd_frame_capture_ctrl
//   Pixel-clock-domain gate between the CCD sensor stream and the frame store.
//   Software issues one-shot DoRun / DoCapture / DoStop pulses. This block forwards
//   exactly one whole frame per capture request. It also produces pixel coordinates,
//   a running frame count and status flags that Nios polls.
//
//   Optional feature macro: FRAME_TIMEOUT_EN
//     defined   -> an armed capture that sees no frame start within TMO_CYC cycles
//                  gives up and goes to DONE with oTimeout set.
//     undefined -> ARMED waits indefinitely and oTimeout is tied low.
//
// Ports
//   clk, resetN            pixel clock, asynchronous active-low reset
//   DoRun/DoCapture/DoStop one-cycle command pulses (priority Stop > Run > Capture)
//   iFVAL/iLVAL/iDATA      raw sensor stream
//   oDATA/oDVAL            captured pixel and its qualifier (2-cycle latency)
//   oX/oY                  column/row of oDATA
//   oFrameCount            frame starts seen since the last DoRun
//   oRunning/oCapturing/oCaptureDone/oTimeout  status flags
`timescale 1ns/1ps
module ccd_frame_capture_ctrl #(
  parameter int DATA_W  = 12,
  parameter int X_W     = 12,
  parameter int Y_W     = 11,
  parameter int FCNT_W  = 16,
  parameter int TMO_CYC = 2**24
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              DoRun,
  input  logic              DoCapture,
  input  logic              DoStop,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic [DATA_W-1:0] iDATA,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic [FCNT_W-1:0] oFrameCount,
  output logic              oRunning,
  output logic              oCapturing,
  output logic              oCaptureDone,
  output logic              oTimeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Two-stage input pipeline: s1 is the capture register, s2 doubles as the
  // output register for data and the reference for edge detection.
  logic              fval_s1_q, lval_s1_q, fval_s2_q, lval_s2_q;
  logic [DATA_W-1:0] data_s1_q, data_s2_q;

  logic              dval_q, dval_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic fval_rise, fval_fall, lval_rise, lval_fall;
  logic run_accept, enter_armed, tmo_hit;

  assign fval_rise = fval_s1_q & ~fval_s2_q;
  assign fval_fall = ~fval_s1_q & fval_s2_q;
  assign lval_rise = lval_s1_q & ~lval_s2_q;
  assign lval_fall = ~lval_s1_q & lval_s2_q;

  assign run_accept  = (state_q == S_IDLE) && DoRun && !DoStop;
  assign enter_armed = (state_d == S_ARMED) && (state_q != S_ARMED);

  // ---------------------------------------------------------------------------
  // Armed timeout (optional)
  // ---------------------------------------------------------------------------
`ifdef FRAME_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TMO_CYC - 1);

  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;

  // First ARMED cycle sees count 0, so the hit lands TMO_CYC cycles after entry.
  assign tmo_hit = (state_q == S_ARMED) && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == S_ARMED) && (state_d == S_ARMED)) begin
      tmo_cnt_d = tmo_cnt_q + 24'(1);
    end

    tmo_d = tmo_q;
    if (run_accept || enter_armed) begin
      tmo_d = 1'b0;
    end else if ((state_q == S_ARMED) && (state_d == S_DONE)) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign oTimeout = tmo_q;
`else
  assign tmo_hit  = 1'b0;
  assign oTimeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    if (DoStop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (DoRun)     state_d = S_RUN;
        S_RUN:     if (DoCapture) state_d = S_ARMED;
        // Only a fresh frame start opens the gate, so a frame already under way
        // when the request arrives is skipped rather than captured partially.
        S_ARMED: begin
          if (fval_rise)    state_d = S_CAPTURE;
          else if (tmo_hit) state_d = S_DONE;
        end
        S_CAPTURE: if (fval_fall) state_d = S_DONE;
        S_DONE:    if (DoCapture) state_d = S_ARMED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values (aligned to the pixel sitting in s1)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Gating on state_d means a DoStop drops oDVAL on the very next cycle, and
    // the frame-start pixel is already valid when CAPTURE is entered.
    dval_d = fval_s1_q & lval_s1_q & (state_d == S_CAPTURE);

    x_d = x_q;
    if (lval_rise) begin
      x_d = '0;
    end else if (fval_s1_q && lval_s1_q && (x_q != '1)) begin
      x_d = x_q + X_W'(1);
    end

    y_d = y_q;
    if (!fval_s1_q) begin
      y_d = '0;
    end else if (lval_fall && (y_q != '1)) begin
      y_d = y_q + Y_W'(1);
    end

    fcnt_d = fcnt_q;
    if (run_accept) begin
      fcnt_d = '0;
    end else if (fval_rise && (state_q != S_IDLE)) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetN) begin
      state_q   <= S_IDLE;
      fval_s1_q <= 1'b0;
      lval_s1_q <= 1'b0;
      data_s1_q <= '0;
      fval_s2_q <= 1'b0;
      lval_s2_q <= 1'b0;
      data_s2_q <= '0;
      dval_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      fval_s1_q <= iFVAL;
      lval_s1_q <= iLVAL;
      data_s1_q <= iDATA;
      fval_s2_q <= fval_s1_q;
      lval_s2_q <= lval_s1_q;
      data_s2_q <= data_s1_q;
      dval_q    <= dval_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign oDATA        = data_s2_q;
  assign oDVAL        = dval_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFrameCount  = fcnt_q;
  assign oRunning     = (state_q != S_IDLE);
  assign oCapturing   = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign oCaptureDone = (state_q == S_DONE);

endmodule
